vram_arbiter: RTL and testbench

- Sits directly upstream of MC6847_VGA and owns the single-port video RAM.
- Time-multiplexes the RAM port between the display fetch (RD/DA/DD) and Z80 CPU accesses.
- Display reads have priority. A starvation counter bounds CPU wait time.
- Produces the registered DD byte that the display consumes.

---
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares single-port video RAM between the display fetch and Z80 CPU.
//            Define VRAM_SNOW_EN for VZ200-style CPU-priority "snow" arbitration.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int AW       = 13,
  parameter int MAX_WAIT = 4,
  parameter int WCW      = 3
) (
  input  logic          PIX_CLK,
  input  logic          RESET_N,
  input  logic          RD,
  input  logic [AW-1:0] DA,
  output logic [7:0]    DD,
  output logic          vid_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_RETURN = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  state_t r_state;
  state_t w_next;
  owner_t r_own1;
  owner_t r_own2;
  logic   r_miss1;
  logic   r_miss2;
  logic   r_cpu_we;
  logic   w_grant;
  logic   w_miss;

`ifdef VRAM_SNOW_EN
  assign w_grant = (r_state == S_IDLE) && cpu_req;
`else
  localparam logic [WCW-1:0] c_MAX_WAIT = WCW'(MAX_WAIT);

  logic [WCW-1:0] r_wait_cnt;

  assign w_grant = (r_state == S_IDLE) && cpu_req &&
                   (!RD || (r_wait_cnt == c_MAX_WAIT));

  // Counts consecutive denied CPU cycles; reaching MAX_WAIT forces the grant.
  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wait_cnt <= '0;
    end else if (!cpu_req || w_grant) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_IDLE) && (r_wait_cnt != c_MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end
`endif

  assign w_miss     = RD && w_grant;
  assign cpu_wait_n = ~(cpu_req & (r_state != S_HOLD));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ISSUED;
      S_ISSUED: w_next = S_RETURN;
      S_RETURN: w_next = S_HOLD;
      S_HOLD:   if (!cpu_req) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_own1    <= OWN_NONE;
      r_own2    <= OWN_NONE;
      r_miss1   <= 1'b0;
      r_miss2   <= 1'b0;
      r_cpu_we  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      DD        <= '0;
      vid_miss  <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      r_state <= w_next;

      // ram_wdata only changes on CPU slots, so it still holds the CPU byte
      // two cycles later when a snow collision needs it.
      if (w_grant) begin
        ram_we    <= cpu_we;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        r_cpu_we  <= cpu_we;
        r_own1    <= OWN_CPU;
      end else if (RD) begin
        ram_we   <= 1'b0;
        ram_addr <= DA;
        r_own1   <= OWN_VID;
      end else begin
        ram_we <= 1'b0;
        r_own1 <= OWN_NONE;
      end

      r_miss1  <= w_miss;
      r_own2   <= r_own1;
      r_miss2  <= r_miss1;
      vid_miss <= r_miss2;

      if (r_own2 == OWN_VID) begin
        DD <= ram_rdata;
      end
`ifdef VRAM_SNOW_EN
      else if (r_miss2) begin
        DD <= r_cpu_we ? ram_wdata : ram_rdata;
      end
`endif

      cpu_ack <= (r_state == S_RETURN);
      if ((r_state == S_RETURN) && !r_cpu_we) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed and randomized checks of vram_arbiter against a
//            schedule-based reference model and a synchronous RAM model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;
  localparam int AW    = 13;
  localparam int MAXW  = 4;
  localparam int NRAND = 1500;

  logic          PIX_CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          RD = 1'b0;
  logic [AW-1:0] DA = '0;
  logic [7:0]    DD;
  logic          vid_miss;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait_n;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0]    vram [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [0:15];
  bit         exp_ack  [0:NRAND+3];
  bit         exp_miss [0:NRAND+3];
  bit         dd_upd   [0:NRAND+3];
  logic [7:0] dd_val   [0:NRAND+3];
  bit         rd_upd   [0:NRAND+3];
  logic [7:0] rd_val   [0:NRAND+3];

  always #5 PIX_CLK = ~PIX_CLK;

  // Synchronous single-port RAM: read data appears one cycle after the address.
  always @(posedge PIX_CLK) begin
    if (pl_en) vram[pl_addr] <= pl_data;
    else if (ram_we) vram[ram_addr] <= ram_wdata;
    ram_rdata <= vram[ram_addr];
  end

  vram_arbiter #(.AW(AW), .MAX_WAIT(MAXW), .WCW(3)) dut (
    .PIX_CLK(PIX_CLK), .RESET_N(RESET_N), .RD(RD), .DA(DA), .DD(DD),
    .vid_miss(vid_miss), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic test_reset();
    RESET_N = 1'b0; RD = 1'b0; cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({DD, vid_miss, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got DD=%h miss=%b rdata=%h ack=%b addr=%h we=%b wdata=%h, expected all zero",
               DD, vid_miss, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata);
    end
    n_cmp++;
    if (cpu_wait_n !== 1'b1) begin
      n_bad++; $display("FAIL reset_wait_n: got %b expected 1", cpu_wait_n);
    end
    for (int a = 0; a < 32; a++) begin
      pl_en = 1'b1; pl_addr = AW'(a);
      pl_data = (a == 5) ? 8'h77 : (a == 16) ? 8'hA5 : 8'($urandom);
      @(negedge PIX_CLK);
    end
    pl_en = 1'b0;
    RESET_N = 1'b1;
  endtask

  task automatic test_display_read();
    RD = 1'b1; DA = AW'(16'h0010);
    @(negedge PIX_CLK);
    RD = 1'b0;
    @(negedge PIX_CLK);
    n_cmp++;
    if (DD !== 8'h00) begin
      n_bad++; $display("FAIL disp_latency_early: got DD=%h expected 00", DD);
    end
    @(negedge PIX_CLK);
    n_cmp++;
    if (DD !== 8'hA5) begin
      n_bad++; $display("FAIL disp_read: got DD=%h expected a5", DD);
    end
    n_cmp++;
    if (vid_miss !== 1'b0) begin
      n_bad++; $display("FAIL disp_no_miss: got %b expected 0", vid_miss);
    end
  endtask

  task automatic test_cpu_write();
    RD = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = AW'(16'h0200); cpu_wdata = 8'h3C;
    #1;
    n_cmp++;
    if (cpu_wait_n !== 1'b0) begin
      n_bad++; $display("FAIL wr_wait_c0: got %b expected 0", cpu_wait_n);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge PIX_CLK);
      n_cmp++;
      if (ram_we !== (c == 1)) begin
        n_bad++; $display("FAIL wr_ram_we c%0d: got %b expected %b", c, ram_we, (c == 1));
      end
      n_cmp++;
      if (cpu_ack !== (c == 3)) begin
        n_bad++; $display("FAIL wr_ack c%0d: got %b expected %b", c, cpu_ack, (c == 3));
      end
      n_cmp++;
      if (cpu_wait_n !== (c >= 3)) begin
        n_bad++; $display("FAIL wr_wait_n c%0d: got %b expected %b", c, cpu_wait_n, (c >= 3));
      end
      if (c == 1) begin
        n_cmp++;
        if (ram_addr !== AW'(16'h0200) || ram_wdata !== 8'h3C) begin
          n_bad++; $display("FAIL wr_ram_bus: got addr=%h data=%h expected 0200/3c", ram_addr, ram_wdata);
        end
      end
      if (c == 3) cpu_req = 1'b0;
    end
    n_cmp++;
    if (vram[16'h0200] !== 8'h3C) begin
      n_bad++; $display("FAIL wr_committed: got %h expected 3c", vram[16'h0200]);
    end
  endtask

  task automatic test_forced_grant();
    logic [AW-1:0] exp_a;
    RD = 1'b1; DA = AW'(16'h0010);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge PIX_CLK);
      exp_a = (c == 5) ? AW'(5) : AW'(16'h0010);
      n_cmp++;
      if (ram_addr !== exp_a) begin
        n_bad++; $display("FAIL force_ram_addr c%0d: got %h expected %h", c, ram_addr, exp_a);
      end
      n_cmp++;
      if (vid_miss !== (c == 7)) begin
        n_bad++; $display("FAIL force_miss c%0d: got %b expected %b", c, vid_miss, (c == 7));
      end
      n_cmp++;
      if (cpu_ack !== (c == 7)) begin
        n_bad++; $display("FAIL force_ack c%0d: got %b expected %b", c, cpu_ack, (c == 7));
      end
      n_cmp++;
      if (DD !== 8'hA5) begin
        n_bad++; $display("FAIL force_dd_hold c%0d: got %h expected a5", c, DD);
      end
      n_cmp++;
      if (cpu_wait_n !== (c >= 7)) begin
        n_bad++; $display("FAIL force_wait_n c%0d: got %b expected %b", c, cpu_wait_n, (c >= 7));
      end
      if (c == 7) begin
        n_cmp++;
        if (cpu_rdata !== 8'h77) begin
          n_bad++; $display("FAIL force_rdata: got %h expected 77", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
    end
    RD = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks1, acks2;
    acks1 = 0; acks2 = 0;
    RD = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(16'h0010);
    for (int c = 1; c <= 19; c++) begin
      @(negedge PIX_CLK);
      if (cpu_ack === 1'b1) begin
        if (c <= 9) acks1++; else acks2++;
      end
      if (c >= 4 && c <= 8) begin
        n_cmp++;
        if (cpu_wait_n !== 1'b1 || cpu_rdata !== 8'hA5) begin
          n_bad++; $display("FAIL hold_state c%0d: got wait_n=%b rdata=%h expected 1/a5", c, cpu_wait_n, cpu_rdata);
        end
      end
      if (c == 9) cpu_req = 1'b0;
      if (c == 10) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(16'h0201); cpu_wdata = 8'h11;
      end
      if (c == 14) cpu_req = 1'b0;
    end
    n_cmp++;
    if (acks1 != 1) begin
      n_bad++; $display("FAIL hold_single_ack: got %0d acks expected 1", acks1);
    end
    n_cmp++;
    if (acks2 != 1) begin
      n_bad++; $display("FAIL b2b_single_ack: got %0d acks expected 1", acks2);
    end
    n_cmp++;
    if (vram[16'h0201] !== 8'h11) begin
      n_bad++; $display("FAIL b2b_write: got %h expected 11", vram[16'h0201]);
    end
  endtask

  task automatic test_drop_in_issued();
    RD = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = AW'(16'h0300); cpu_wdata = 8'h99;
    for (int c = 1; c <= 6; c++) begin
      @(negedge PIX_CLK);
      if (c == 1) cpu_req = 1'b0;
      n_cmp++;
      if (cpu_ack !== (c == 3)) begin
        n_bad++; $display("FAIL drop_ack c%0d: got %b expected %b", c, cpu_ack, (c == 3));
      end
    end
    n_cmp++;
    if (vram[16'h0300] !== 8'h99) begin
      n_bad++; $display("FAIL drop_write: got %h expected 99", vram[16'h0300]);
    end
  endtask

  task automatic test_reset_mid_access();
    RD = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
    @(negedge PIX_CLK);
    @(negedge PIX_CLK);
    RESET_N = 1'b0; cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({DD, vid_miss, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata} !== '0 || cpu_wait_n !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_outputs: got DD=%h rdata=%h ack=%b addr=%h wait_n=%b expected zeros/wait_n=1",
               DD, cpu_rdata, cpu_ack, ram_addr, cpu_wait_n);
    end
    @(negedge PIX_CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00) begin
        n_bad++; $display("FAIL midreset_no_ack c%0d: got ack=%b rdata=%h expected 0/00", c, cpu_ack, cpu_rdata);
      end
      @(negedge PIX_CLK);
    end
  endtask

  // Reference: each grant schedules its visible effects three cycles ahead.
  task automatic test_random();
    int         g, wc;
    bit         active, acked, idle, hold, grant, exp_wn;
    logic [7:0] m_dd, m_rd;
    RESET_N = 1'b0; RD = 1'b0; cpu_req = 1'b0;
    @(negedge PIX_CLK);
    RESET_N = 1'b1;
    for (int a = 0; a < 16; a++) ref_mem[a] = vram[a];
    for (int i = 0; i <= NRAND + 3; i++) begin
      exp_ack[i] = 0; exp_miss[i] = 0; dd_upd[i] = 0; rd_upd[i] = 0;
      dd_val[i] = '0; rd_val[i] = '0;
    end
    g = 0; wc = 0; active = 0; acked = 0; m_dd = '0; m_rd = '0;
    for (int c = 0; c < NRAND; c++) begin
      if (dd_upd[c]) m_dd = dd_val[c];
      if (rd_upd[c]) m_rd = rd_val[c];
      if (exp_ack[c]) acked = 1;
      n_cmp++;
      if (DD !== m_dd) begin
        n_bad++; $display("FAIL rand_dd c%0d: got %h expected %h", c, DD, m_dd);
      end
      n_cmp++;
      if (vid_miss !== exp_miss[c]) begin
        n_bad++; $display("FAIL rand_miss c%0d: got %b expected %b", c, vid_miss, exp_miss[c]);
      end
      n_cmp++;
      if (cpu_ack !== exp_ack[c]) begin
        n_bad++; $display("FAIL rand_ack c%0d: got %b expected %b", c, cpu_ack, exp_ack[c]);
      end
      n_cmp++;
      if (cpu_rdata !== m_rd) begin
        n_bad++; $display("FAIL rand_rdata c%0d: got %h expected %h", c, cpu_rdata, m_rd);
      end

      RD = ($urandom_range(0, 3) != 0);
      DA = AW'($urandom_range(0, 15));
      if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
          acked = 0;
        end
      end else if (acked ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0)) begin
        cpu_req = 1'b0;
      end
      #1;

      hold   = active && (c >= g + 3);
      exp_wn = !(cpu_req && !hold);
      idle   = !active;
      grant  = idle && cpu_req && (!RD || wc == MAXW);
      if (grant) begin
        g = c; active = 1; wc = 0;
        exp_ack[c+3] = 1;
        if (cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
        else begin rd_upd[c+3] = 1; rd_val[c+3] = ref_mem[cpu_addr[3:0]]; end
        if (RD) exp_miss[c+3] = 1;
      end else begin
        if (!cpu_req) wc = 0;
        else if (idle && wc < MAXW) wc++;
        if (RD) begin dd_upd[c+3] = 1; dd_val[c+3] = ref_mem[DA[3:0]]; end
      end
      if (hold && !cpu_req) active = 0;

      n_cmp++;
      if (cpu_wait_n !== exp_wn) begin
        n_bad++; $display("FAIL rand_wait_n c%0d: got %b expected %b", c, cpu_wait_n, exp_wn);
      end
      @(negedge PIX_CLK);
    end
    RD = 1'b0; cpu_req = 1'b0;
  endtask

  initial begin
    @(negedge PIX_CLK);
    test_reset();
    @(negedge PIX_CLK);
    test_display_read();
    @(negedge PIX_CLK);
    test_cpu_write();
    @(negedge PIX_CLK);
    test_forced_grant();
    @(negedge PIX_CLK);
    test_back_to_back();
    @(negedge PIX_CLK);
    test_drop_in_issued();
    @(negedge PIX_CLK);
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
